regfile_mp: RTL and testbench
=============================

# regfile_mp

Multi-port, parametrised integer register file for the pipelined RV32I core. It replaces the fixed 2-read/1-write array with configurable read and write port counts, same-cycle write-to-read bypass on every read port, and a per-register busy scoreboard for hazard detection. Its reset is a sequenced clear, one entry per cycle, with a ready indication. It sits between decode (reads, issue) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous and active-high
- rd_addr_i  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rd_data_o  output  NRD*XLEN  read data, combinational, port k at [k*XLEN +: XLEN]
- rd_busy_o  output  NRD  busy bit of each addressed register, combinational
- wr_en_i  input  NWR  per-port write enable
- wr_addr_i  input  NWR*AW  write addresses
- wr_data_i  input  NWR*XLEN  write data
- issue_en_i  input  1  marks issue_rd_i as having a pending producer
- issue_rd_i  input  AW  destination register of the issuing instruction
- ready_o  output  1  high once the clear sequence is complete

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector. Register 0 always reads 0, is never busy, and ignores writes and issues.
- FSM states: CLEAR and READY.
  - rst_i high: state becomes CLEAR and clr_cnt becomes 0.
  - In CLEAR, each cycle with rst_i low zeroes reg[clr_cnt] and busy[clr_cnt], then increments clr_cnt.
  - When clr_cnt = NREGS-1, that entry is cleared and the state moves to READY.
  - READY is held until the next rst_i.
- In CLEAR:
  - wr_en_i and issue_en_i are ignored.
  - rd_data_o = 0 and rd_busy_o = 0 on all ports.
  - ready_o = 0.
- Write (READY): on the rising edge, for each port j with wr_en_i[j] and addr ≠ 0, reg[addr] <= data and busy[addr] <= 0.
  - If several ports write the same address, the highest-indexed port wins.
- Read (READY): rd_data_o[k] is selected in this order:
  1. 0 if the address is 0.
  2. Otherwise, data of the highest-indexed enabled write port whose address matches (bypass).
  3. Otherwise, the stored value.
- Busy (READY): rd_busy_o[k] = busy[addr] & ~(any enabled write port matches addr), with the addr-0 term forced to 0.
  - The bypass also clears the visible busy bit in the same cycle.
- Issue (READY): issue_en_i with issue_rd_i ≠ 0 sets busy[issue_rd_i].
  - If an issue and a write target the same register in the same cycle, the set wins: busy ends 1 and the data is still written.

## Timing
- Reset values: state = CLEAR, clr_cnt = 0, ready_o = 0. Array and busy contents are undefined until cleared.
- Clear latency: ready_o rises NREGS rising edges after the first edge at which rst_i is sampled low. With the defaults, that is the 32nd edge.
- rst_i asserted mid-clear or in READY restarts the sequence from entry 0 on the next edge.
- Read data and busy are zero-latency (combinational) from addresses and write inputs. The stored value is visible on the edge after the write.
- Busy set by an issue is visible to reads on the cycle after issue_en_i. It is not bypassed.
- All writes to distinct registers in one cycle commit together.

## Test plan
- Reset then clear: hold rst_i 3 cycles, release. Required: ready_o = 0 for 32 edges, 1 after the 32nd; every register reads 0 and every busy bit is 0.
- Write/readback: write 0xDEADBEEF to x5 via port 0. Required: rd_data_o port 1 (addr 5) shows 0xDEADBEEF in the same cycle (bypass) and on every later cycle.
- Write collision: port 0 writes 0x11 and port 1 writes 0x22, both to x7, same cycle. Required: bypass and stored value are both 0x22. A write of 0x1234 to x0 must read back 0.
- Scoreboard: issue x9, next cycle rd_busy_o = 1 for x9. Write x9 with 0x55: same-cycle busy = 0 and data = 0x55. Issue and write x9 in the same cycle: busy = 1 afterwards.
- Reset mid-clear: assert rst_i at clr_cnt = 10 for 1 cycle. Required: ready_o stays 0, then rises exactly 32 edges after release.
- Writes during CLEAR: a write of 0xAA to x3 while ready_o = 0 is dropped. Required: x3 reads 0 after ready_o rises.

Source files
------------

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file for the pipelined RV32I core. It provides
// NRD combinational read ports, NWR write ports with same-cycle write-to-read
// bypass, and a per-register busy scoreboard used by decode to detect RAW
// hazards against instructions still in flight.
//
// After reset the array is cleared one entry per cycle. While that sequence
// runs, all reads return zero, writes and issues are dropped, and ready_o
// stays low. Register x0 always reads zero, is never busy, and ignores both
// writes and issues.
//
// Ports
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset, restarts the clear sequence
//   rd_addr_i   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data_o   NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy_o   busy bit of the register addressed by each read port
//   wr_en_i     per write port enable
//   wr_addr_i   NWR packed write addresses
//   wr_data_i   NWR packed write data
//   issue_en_i  marks issue_rd_i as having a pending producer
//   issue_rd_i  destination register of the issuing instruction
//   ready_o     high once every entry has been cleared
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   input  logic                issue_en_i,
   input  logic [AW-1:0]       issue_rd_i,
   output logic                ready_o
);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   localparam logic [AW-1:0] LAST_ENTRY = AW'(NREGS - 1);

   state_e              state_q;
   state_e              state_d;
   logic [AW-1:0]       clrCnt_q;
   logic [AW-1:0]       clrCnt_d;

   logic [XLEN-1:0]     mem_q [NREGS];
   logic [XLEN-1:0]     mem_d [NREGS];
   logic [NREGS-1:0]    busy_q;
   logic [NREGS-1:0]    busy_d;

   logic [AW-1:0]       rdAddr   [NRD];
   logic [XLEN-1:0]     rdData   [NRD];
   logic                rdBusy   [NRD];
   logic [AW-1:0]       wrAddr   [NWR];
   logic [XLEN-1:0]     wrData   [NWR];

   // Unpack the flat port buses into per-port arrays so the read, write and
   // bypass logic below can be written as plain loops over port indices.
   for (genvar k = 0; k < NRD; k++) begin : gRdPort
      assign rdAddr[k]                  = rd_addr_i[k*AW +: AW];
      assign rd_data_o[k*XLEN +: XLEN]  = rdData[k];
      assign rd_busy_o[k]               = rdBusy[k];
   end

   for (genvar j = 0; j < NWR; j++) begin : gWrPort
      assign wrAddr[j] = wr_addr_i[j*AW +: AW];
      assign wrData[j] = wr_data_i[j*XLEN +: XLEN];
   end

   // FSM state register. Reset forces the clear sequence to restart from
   // entry 0 regardless of where it was, including from READY.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= CLEAR;
         clrCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         clrCnt_q <= clrCnt_d;
      end
   end

   // FSM next state. CLEAR walks the counter across every entry and hands
   // over to READY on the cycle the last entry is cleared; READY is held
   // until the next reset.
   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      case (state_q)
         CLEAR: begin
            clrCnt_d = clrCnt_q + AW'(1);
            if (clrCnt_q == LAST_ENTRY) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Next contents of the array and the busy vector. During CLEAR only the
   // entry under the counter changes. In READY the write ports are applied in
   // ascending order so the highest-indexed port wins a collision, and the
   // issue is applied last so a same-cycle issue leaves the register busy
   // even though its data is still written. Nothing changes while reset is
   // asserted, since the contents are undefined until cleared anyway.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (!rst_i) begin
         if (state_q == CLEAR) begin
            mem_d[clrCnt_q]  = '0;
            busy_d[clrCnt_q] = 1'b0;
         end else begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en_i[j] && (wrAddr[j] != '0)) begin
                  mem_d[wrAddr[j]]  = wrData[j];
                  busy_d[wrAddr[j]] = 1'b0;
               end
            end
            if (issue_en_i && (issue_rd_i != '0)) begin
               busy_d[issue_rd_i] = 1'b1;
            end
         end
      end
   end

   // Storage update. The array carries no reset; the clear sequence is what
   // gives it a defined value.
   always_ff @(posedge clk_i) begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
   end

   // Combinational read ports. x0 and the CLEAR state both read as zero and
   // not busy. Otherwise an enabled write to the same address bypasses the
   // stored value, with the highest-indexed matching port taking priority,
   // and that pending write also hides the busy bit because the producer is
   // completing this very cycle. Issues are deliberately not bypassed.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rdData[k] = '0;
         rdBusy[k] = 1'b0;
         if ((state_q == READY) && (rdAddr[k] != '0)) begin
            rdData[k] = mem_q[rdAddr[k]];
            rdBusy[k] = busy_q[rdAddr[k]];
            for (int j = 0; j < NWR; j++) begin
               if (wr_en_i[j] && (wrAddr[j] == rdAddr[k])) begin
                  rdData[k] = wrData[j];
                  rdBusy[k] = 1'b0;
               end
            end
         end
      end
   end

   // Ready tracks the FSM directly so it is low throughout the clear
   // sequence and rises on the edge that clears the final entry.
   assign ready_o = (state_q == READY);

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed testbench for regfile_mp with its default parameters (XLEN=32,
// NREGS=32, NRD=2, NWR=2). Inputs change 1 ns after a rising edge and outputs
// are sampled 1 ns later, well clear of the next rising edge. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk_i;
   logic                rst_i;
   logic [NRD*AW-1:0]   rd_addr_i;
   logic [NRD*XLEN-1:0] rd_data_o;
   logic [NRD-1:0]      rd_busy_o;
   logic [NWR-1:0]      wr_en_i;
   logic [NWR*AW-1:0]   wr_addr_i;
   logic [NWR*XLEN-1:0] wr_data_i;
   logic                issue_en_i;
   logic [AW-1:0]       issue_rd_i;
   logic                ready_o;

   int checkCount;
   int failCount;

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_addr_i  (rd_addr_i),
      .rd_data_o  (rd_data_o),
      .rd_busy_o  (rd_busy_o),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .issue_en_i (issue_en_i),
      .issue_rd_i (issue_rd_i),
      .ready_o    (ready_o)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Counts one comparison and reports it if observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one write port; a zero enable leaves the port idle.
   task automatic applyStimulus(input int port, input logic en,
                                input logic [AW-1:0] addr, input logic [31:0] data);
      wr_en_i[port]                 = en;
      wr_addr_i[port*AW +: AW]      = addr;
      wr_data_i[port*XLEN +: XLEN]  = data;
   endtask

   // Points both read ports at the given registers.
   task automatic setReads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr_i[0 +: AW]  = a0;
      rd_addr_i[AW +: AW] = a1;
   endtask

   // Drops all write and issue activity.
   task automatic idleInputs();
      wr_en_i    = '0;
      wr_addr_i  = '0;
      wr_data_i  = '0;
      issue_en_i = 1'b0;
      issue_rd_i = '0;
   endtask

   // Advances to 1 ns past the next rising edge, where inputs may change.
   task automatic stepClock();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_i      = 1'b1;
      rd_addr_i  = '0;
      idleInputs();

      // Reset held for three edges, then the clear sequence.
      stepClock();
      stepClock();
      stepClock();
      #1;
      checkOutput("reset_ready", 32'(ready_o), 32'd0);
      rst_i = 1'b0;
      setReads(5'd3, 5'd3);
      applyStimulus(0, 1'b1, 5'd3, 32'h0000_00AA);
      for (int e = 1; e <= NREGS; e++) begin
         stepClock();
         if (e == 10) begin
            idleInputs();
         end
         #1;
         if (e == 5) begin
            checkOutput("clear_rd_data_zero", rd_data_o[31:0], 32'd0);
            checkOutput("clear_rd_busy_zero", 32'(rd_busy_o[0]), 32'd0);
         end
         checkOutput($sformatf("clear_ready_e%0d", e), 32'(ready_o),
                     (e == NREGS) ? 32'd1 : 32'd0);
      end

      // Every register reads zero and not busy after the clear.
      for (int r = 0; r < NREGS; r++) begin
         setReads(5'(r), 5'(r));
         #1;
         checkOutput($sformatf("cleared_data_x%0d", r), rd_data_o[63:32], 32'd0);
         checkOutput($sformatf("cleared_busy_x%0d", r), 32'(rd_busy_o[1]), 32'd0);
      end
      setReads(5'd3, 5'd0);
      #1;
      checkOutput("clear_write_dropped_x3", rd_data_o[31:0], 32'd0);

      // Write x5 through port 0 with a same-cycle bypass on port 1.
      setReads(5'd0, 5'd5);
      applyStimulus(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      checkOutput("bypass_x5", rd_data_o[63:32], 32'hDEAD_BEEF);
      stepClock();
      idleInputs();
      #1;
      checkOutput("stored_x5", rd_data_o[63:32], 32'hDEAD_BEEF);
      stepClock();
      #1;
      checkOutput("stored_x5_later", rd_data_o[63:32], 32'hDEAD_BEEF);

      // Both ports write x7; port 1 must win in the bypass and in storage.
      setReads(5'd7, 5'd5);
      applyStimulus(0, 1'b1, 5'd7, 32'h0000_0011);
      applyStimulus(1, 1'b1, 5'd7, 32'h0000_0022);
      #1;
      checkOutput("collision_bypass_x7", rd_data_o[31:0], 32'h0000_0022);
      stepClock();
      idleInputs();
      #1;
      checkOutput("collision_stored_x7", rd_data_o[31:0], 32'h0000_0022);

      // Writes to x0 are discarded and never bypassed.
      setReads(5'd0, 5'd7);
      applyStimulus(0, 1'b1, 5'd0, 32'h0000_1234);
      #1;
      checkOutput("x0_bypass_zero", rd_data_o[31:0], 32'd0);
      stepClock();
      idleInputs();
      #1;
      checkOutput("x0_stored_zero", rd_data_o[31:0], 32'd0);

      // Two distinct registers written in the same cycle both commit.
      applyStimulus(0, 1'b1, 5'd10, 32'h0000_000A);
      applyStimulus(1, 1'b1, 5'd11, 32'h0000_000B);
      stepClock();
      idleInputs();
      setReads(5'd10, 5'd11);
      #1;
      checkOutput("dual_write_x10", rd_data_o[31:0], 32'h0000_000A);
      checkOutput("dual_write_x11", rd_data_o[63:32], 32'h0000_000B);

      // Issue x9: busy is not bypassed, then visible the following cycle.
      setReads(5'd9, 5'd9);
      issue_en_i = 1'b1;
      issue_rd_i = 5'd9;
      #1;
      checkOutput("issue_not_bypassed", 32'(rd_busy_o[0]), 32'd0);
      stepClock();
      idleInputs();
      #1;
      checkOutput("issue_busy_x9", 32'(rd_busy_o[0]), 32'd1);

      // Writeback to x9 hides busy in the same cycle and clears it after.
      applyStimulus(1, 1'b1, 5'd9, 32'h0000_0055);
      #1;
      checkOutput("wb_bypass_busy_x9", 32'(rd_busy_o[0]), 32'd0);
      checkOutput("wb_bypass_data_x9", rd_data_o[31:0], 32'h0000_0055);
      stepClock();
      idleInputs();
      #1;
      checkOutput("wb_busy_cleared_x9", 32'(rd_busy_o[1]), 32'd0);
      checkOutput("wb_stored_x9", rd_data_o[63:32], 32'h0000_0055);

      // Issue and write to x9 in the same cycle: busy set wins, data lands.
      applyStimulus(0, 1'b1, 5'd9, 32'h0000_0066);
      issue_en_i = 1'b1;
      issue_rd_i = 5'd9;
      stepClock();
      idleInputs();
      #1;
      checkOutput("issue_wins_busy_x9", 32'(rd_busy_o[0]), 32'd1);
      checkOutput("issue_wins_data_x9", rd_data_o[31:0], 32'h0000_0066);

      // Issue to x0 never makes it busy.
      setReads(5'd0, 5'd0);
      issue_en_i = 1'b1;
      issue_rd_i = 5'd0;
      stepClock();
      idleInputs();
      #1;
      checkOutput("issue_x0_not_busy", 32'(rd_busy_o[0]), 32'd0);

      // Reset, then a one-cycle reset again when the counter reaches 10.
      rst_i = 1'b1;
      stepClock();
      rst_i = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         stepClock();
      end
      #1;
      checkOutput("midclear_ready_low", 32'(ready_o), 32'd0);
      rst_i = 1'b1;
      stepClock();
      rst_i = 1'b0;
      for (int e = 1; e <= NREGS; e++) begin
         stepClock();
         #1;
         if (e >= NREGS - 1) begin
            checkOutput($sformatf("restart_ready_e%0d", e), 32'(ready_o),
                        (e == NREGS) ? 32'd1 : 32'd0);
         end else if (e == 16) begin
            checkOutput("restart_ready_e16", 32'(ready_o), 32'd0);
         end
      end
      setReads(5'd9, 5'd5);
      #1;
      checkOutput("restart_x9_data", rd_data_o[31:0], 32'd0);
      checkOutput("restart_x9_busy", 32'(rd_busy_o[0]), 32'd0);
      checkOutput("restart_x5_data", rd_data_o[63:32], 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
